// File: rtl/vram_heatmap_stream.sv
// Two-pass VRAM heatmap converter: scan for the frame maximum, then stream each pixel
// normalised to 8 bits as AXI4-Stream RGB888. Define HEATMAP_COLORMAP_EN for the "hot" colormap stage.
module vram_heatmap_stream #(
    parameter int NPIX       = 9216,
    parameter int LINE_W     = 96,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_vdma,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic [13:0] addr_vdma,
    input  logic [63:0] data_vdma,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        frame_done,
    output logic [63:0] frame_max,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_CALC   = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COLW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    localparam logic [13:0]     NPIX_C   = 14'(NPIX);
    localparam logic [13:0]     LAST_PIX = 14'(NPIX - 1);
    localparam logic [COLW-1:0] LAST_COL = COLW'(LINE_W - 1);
    localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [1:0]      state_q, state_d;
    logic [13:0]     addr_q, addr_d;
    logic [13:0]     rx_cnt_q, rx_cnt_d;
    logic [13:0]     out_cnt_q, out_cnt_d;
    logic [COLW-1:0] col_q, col_d;
    logic [63:0]     max_q, max_d;
    logic [63:0]     frame_max_q, frame_max_d;
    logic [5:0]      sh_q, sh_d;
    logic            done_q, done_d;
    logic [RD_LAT-1:0] vld_q;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [25:0]     fifo_mem [FIFO_DEPTH];

    logic        scan_issue;
    logic        stream_issue;
    logic        rd_issue;
    logic        rd_ret;
    logic        pix_ret;
    logic        credit_ok;
    logic [63:0] word_pos;
    logic [63:0] shifted;
    logic [7:0]  pix_v;
    logic        pix_user;
    logic        pix_last;
    logic        push;
    logic [25:0] push_ent;
    logic        pop;
    logic [25:0] head;
    logic [5:0]  msb_c;
    logic [5:0]  sh_c;

    // Reads are only issued while the FIFO plus everything still in flight has room,
    // so a returning word can always be pushed without a full check.
    assign credit_ok    = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_C;
    assign scan_issue   = (state_q == ST_SCAN) && (addr_q < NPIX_C);
    assign stream_issue = (state_q == ST_STREAM) && (addr_q < NPIX_C) && credit_ok;
    assign rd_issue     = scan_issue | stream_issue;
    assign rd_ret       = vld_q[RD_LAT-1];
    assign pix_ret      = rd_ret && (state_q == ST_STREAM);

    assign word_pos = data_vdma[63] ? 64'd0 : data_vdma;
    assign shifted  = data_vdma >> sh_q;
    assign pix_v    = data_vdma[63] ? 8'd0 : ((|shifted[63:8]) ? 8'hFF : shifted[7:0]);
    assign pix_user = (rx_cnt_q == 14'd0);
    assign pix_last = (col_q == LAST_COL);

    always_comb begin
        msb_c = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (max_q[i]) msb_c = 6'(i);
        end
        sh_c = (msb_c > 6'd7) ? (msb_c - 6'd7) : 6'd0;
    end

`ifdef HEATMAP_COLORMAP_EN
    logic        cm_vld_q;
    logic [25:0] cm_ent_q;

    function automatic logic [23:0] hot_map(input logic [7:0] v);
        logic [9:0] t;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        t = {2'b00, v} + {1'b0, v, 1'b0};
        r = (t > 10'd255) ? 8'hFF : t[7:0];
        g = (t > 10'd510) ? 8'hFF : ((t > 10'd255) ? 8'(t - 10'd255) : 8'h00);
        b = (t > 10'd510) ? 8'(t - 10'd510) : 8'h00;
        return {r, g, b};
    endfunction

    always_ff @(posedge clk_vdma or negedge rst_n) begin
        if (!rst_n) begin
            cm_vld_q <= 1'b0;
            cm_ent_q <= '0;
        end else begin
            cm_vld_q <= pix_ret;
            if (pix_ret) cm_ent_q <= {hot_map(pix_v), pix_user, pix_last};
        end
    end

    assign push     = cm_vld_q;
    assign push_ent = cm_ent_q;
`else
    assign push     = pix_ret;
    assign push_ent = {pix_v, pix_v, pix_v, pix_user, pix_last};
`endif

    // AXI-Stream: tvalid follows FIFO occupancy; the head entry is held until tvalid&tready pops it.
    assign head          = fifo_mem[rd_ptr_q];
    assign pop           = (fifo_cnt_q != '0) && m_axis_tready;
    assign m_axis_tvalid = (fifo_cnt_q != '0);
    assign m_axis_tdata  = head[25:2];
    assign m_axis_tuser  = head[1] & m_axis_tvalid;
    assign m_axis_tlast  = head[0] & m_axis_tvalid;

    assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    assign inflight_d = inflight_q + CW'(stream_issue) - CW'(push);
    assign wr_ptr_d   = push ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    assign rd_ptr_d   = pop  ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rx_cnt_d    = rx_cnt_q;
        out_cnt_d   = out_cnt_q;
        col_d       = col_q;
        max_d       = max_q;
        frame_max_d = frame_max_q;
        sh_d        = sh_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d  = ST_SCAN;
                    addr_d   = 14'd0;
                    rx_cnt_d = 14'd0;
                    max_d    = 64'd0;
                end
            end
            ST_SCAN: begin
                if (scan_issue) addr_d = addr_q + 14'd1;
                if (rd_ret) begin
                    if (word_pos > max_q) max_d = word_pos;
                    rx_cnt_d = rx_cnt_q + 14'd1;
                    if (rx_cnt_q == LAST_PIX) state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                frame_max_d = max_q;
                sh_d        = sh_c;
                addr_d      = 14'd0;
                rx_cnt_d    = 14'd0;
                out_cnt_d   = 14'd0;
                col_d       = '0;
                state_d     = ST_STREAM;
            end
            default: begin
                if (stream_issue) addr_d = addr_q + 14'd1;
                if (pix_ret) begin
                    rx_cnt_d = rx_cnt_q + 14'd1;
                    col_d    = pix_last ? '0 : col_q + 1'b1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 14'd1;
                    if (out_cnt_q == LAST_PIX) begin
                        state_d = ST_IDLE;
                        addr_d  = 14'd0;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_vdma or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 14'd0;
            rx_cnt_q    <= 14'd0;
            out_cnt_q   <= 14'd0;
            col_q       <= '0;
            max_q       <= 64'd0;
            frame_max_q <= 64'd0;
            sh_q        <= 6'd0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rx_cnt_q    <= rx_cnt_d;
            out_cnt_q   <= out_cnt_d;
            col_q       <= col_d;
            max_q       <= max_d;
            frame_max_q <= frame_max_d;
            sh_q        <= sh_d;
            done_q      <= done_d;
            vld_q[0]    <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_vdma or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr_q] <= push_ent;
        end
    end

    assign addr_vdma   = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign frame_max   = frame_max_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vram_heatmap_stream.sv
// Directed bench for vram_heatmap_stream: a full-size instance for ramp/backpressure/abort
// frames and a 192-pixel instance for the zero, negative-clamp and mapping frames.
module tb_vram_heatmap_stream;

  localparam int NPIX_A = 9216;
  localparam int NPIX_B = 192;
  localparam int LINE_W = 96;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic tready;
  logic sel;

  logic [13:0] addr_a, addr_b;
  logic [63:0] data_a, data_b;
  logic [23:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [63:0] max_a, max_b;
  logic [1:0]  state_a, state_b;

  logic [23:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, m_busy, m_done;
  logic [63:0] m_max;
  logic [1:0]  m_state;

  logic [63:0] vram [0:NPIX_A-1];
  logic [23:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  int          beats, bad_data, bad_flags, bad_stable, done_cnt;
  bit          tmo;
  logic [23:0] d0, d1, dl;
  logic        be;

  always #5 clk = ~clk;

  vram_heatmap_stream #(.NPIX(NPIX_A), .LINE_W(LINE_W), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut (
    .clk_vdma(clk), .rst_n(rst_n), .frame_start(frame_start & ~sel),
    .addr_vdma(addr_a), .data_vdma(data_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready),
    .m_axis_tuser(tuser_a), .m_axis_tlast(tlast_a),
    .busy(busy_a), .frame_done(done_a), .frame_max(max_a), .dbg_state_o(state_a)
  );

  vram_heatmap_stream #(.NPIX(NPIX_B), .LINE_W(LINE_W), .RD_LAT(1), .FIFO_DEPTH(4)) u_small (
    .clk_vdma(clk), .rst_n(rst_n), .frame_start(frame_start & sel),
    .addr_vdma(addr_b), .data_vdma(data_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready),
    .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b),
    .busy(busy_b), .frame_done(done_b), .frame_max(max_b), .dbg_state_o(state_b)
  );

  // VRAM model with one clock of read latency
  always @(posedge clk) begin
    data_a <= (addr_a < 14'(NPIX_A)) ? vram[addr_a] : 64'd0;
    data_b <= (addr_b < 14'(NPIX_B)) ? vram[addr_b] : 64'd0;
  end

  assign m_tdata  = sel ? tdata_b  : tdata_a;
  assign m_tvalid = sel ? tvalid_b : tvalid_a;
  assign m_tuser  = sel ? tuser_b  : tuser_a;
  assign m_tlast  = sel ? tlast_b  : tlast_a;
  assign m_busy   = sel ? busy_b   : busy_a;
  assign m_done   = sel ? done_b   : done_a;
  assign m_max    = sel ? max_b    : max_a;
  assign m_state  = sel ? state_b  : state_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] map_v(input int v);
`ifdef HEATMAP_COLORMAP_EN
    int t, r, g, b;
    t = 3 * v;
    r = (t > 255) ? 255 : t;
    g = t - 255;
    g = (g < 0) ? 0 : ((g > 255) ? 255 : g);
    b = t - 510;
    b = (b < 0) ? 0 : b;
    return {r[7:0], g[7:0], b[7:0]};
`else
    return {v[7:0], v[7:0], v[7:0]};
`endif
  endfunction

  task automatic load_exp(input int npix, input int sh);
    logic [63:0] w;
    logic [63:0] s;
    int v;
    exp_q.delete();
    for (int i = 0; i < npix; i++) begin
      w = vram[i];
      s = w >> sh;
      if (w[63]) v = 0;
      else v = (s > 64'd255) ? 255 : int'(s[7:0]);
      exp_q.push_back(map_v(v));
    end
  endtask

  task automatic run_frame(input int npix, input int ready_pct, input int abort_beat, input bit poke);
    bit          prev_stall;
    logic [23:0] prev_data;
    logic [23:0] e;
    int          trail;
    beats = 0; bad_data = 0; bad_flags = 0; bad_stable = 0; done_cnt = 0; tmo = 1'b1;
    d0 = '0; d1 = '0; dl = '0;
    prev_stall = 1'b0; prev_data = '0; trail = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    be = m_busy;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (m_done) done_cnt++;
      if (beats == npix) begin
        trail++;
        if (trail == 3) begin
          tmo = 1'b0;
          break;
        end
        continue;
      end
      if (abort_beat > 0 && beats == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", m_tvalid, 0);
        check("abort_state", m_state, 0);
        check("abort_busy", m_busy, 0);
        tmo = 1'b0;
        break;
      end
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) bad_stable++;
      tready = ($urandom_range(99) < ready_pct);
      if (poke && (cyc == 100 || cyc == 12000)) frame_start = 1'b1;
      if (m_tvalid && tready) begin
        if (exp_q.size() == 0) bad_data++;
        else begin
          e = exp_q.pop_front();
          if (m_tdata !== e) bad_data++;
        end
        if (m_tuser !== 1'(beats == 0)) bad_flags++;
        if (m_tlast !== 1'((beats % LINE_W) == LINE_W - 1)) bad_flags++;
        if (beats == 0) d0 = m_tdata;
        if (beats == 1) d1 = m_tdata;
        if (beats == npix - 1) dl = m_tdata;
        beats++;
      end
      prev_stall = m_tvalid && !tready;
      prev_data  = m_tdata;
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; tready = 1'b0; sel = 1'b0;
    for (int i = 0; i < NPIX_A; i++) vram[i] = 64'(i);
    repeat (3) @(negedge clk);

    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_max", m_max, 0);
    check("rst_addr", addr_a, 0);
    check("rst_state", m_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ramp frame, tready high, stray frame_start pulses in SCAN and STREAM
    load_exp(NPIX_A, 6);
    run_frame(NPIX_A, 100, 0, 1'b1);
    check("ramp_timeout", tmo, 0);
    check("ramp_busy_start", be, 1);
    check("ramp_beats", beats, 9216);
    check("ramp_data", bad_data, 0);
    check("ramp_flags", bad_flags, 0);
    check("ramp_done", done_cnt, 1);
    check("ramp_max", m_max, 64'd9215);
    check("ramp_pix0", d0, 24'h000000);
    check("ramp_pix9215", dl, map_v(143));
    check("ramp_busy_end", m_busy, 0);
    check("ramp_state_end", m_state, 0);

    // reset pulled at pixel 4000
    load_exp(NPIX_A, 6);
    run_frame(NPIX_A, 100, 4000, 1'b0);
    check("abort_timeout", tmo, 0);
    check("abort_beats", beats, 4000);
    check("abort_data", bad_data, 0);
    @(negedge clk);
    check("abort_max_cleared", m_max, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ramp frame again under 30% tready
    load_exp(NPIX_A, 6);
    run_frame(NPIX_A, 30, 0, 1'b0);
    check("bp_timeout", tmo, 0);
    check("bp_beats", beats, 9216);
    check("bp_data", bad_data, 0);
    check("bp_flags", bad_flags, 0);
    check("bp_stable", bad_stable, 0);
    check("bp_done", done_cnt, 1);
    check("bp_max", m_max, 64'd9215);
    check("bp_pix9215", dl, map_v(143));
    tready = 1'b0;

    // small instance: all-zero frame
    @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < NPIX_B; i++) vram[i] = 64'd0;
    load_exp(NPIX_B, 0);
    run_frame(NPIX_B, 100, 0, 1'b0);
    check("zero_timeout", tmo, 0);
    check("zero_beats", beats, 192);
    check("zero_data", bad_data, 0);
    check("zero_flags", bad_flags, 0);
    check("zero_done", done_cnt, 1);
    check("zero_max", m_max, 0);
    check("zero_last", dl, 24'h000000);

    // negative clamp
    vram[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    vram[1] = 64'd1000;
    load_exp(NPIX_B, 2);
    run_frame(NPIX_B, 100, 0, 1'b0);
    check("neg_timeout", tmo, 0);
    check("neg_max", m_max, 64'd1000);
    check("neg_pix0", d0, 24'h000000);
    check("neg_pix1", d1, map_v(250));
    check("neg_data", bad_data, 0);
    check("neg_flags", bad_flags, 0);

    // max 255 gives shift 0: v = 100, 255, ..., 50
    vram[0] = 64'd100;
    vram[1] = 64'd255;
    vram[NPIX_B-1] = 64'd50;
    load_exp(NPIX_B, 0);
    run_frame(NPIX_B, 100, 0, 1'b0);
    check("map_timeout", tmo, 0);
    check("map_max", m_max, 64'd255);
    check("map_data", bad_data, 0);
`ifdef HEATMAP_COLORMAP_EN
    check("map_v100", d0, 24'hFF2D00);
    check("map_v255", d1, 24'hFFFFFF);
    check("map_v50", dl, 24'h960000);
`else
    check("map_v100", d0, 24'h646464);
    check("map_v255", d1, 24'hFFFFFF);
    check("map_v50", dl, 24'h323232);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_heatmap_stream.md
Name: vram_heatmap_stream

Overview:
- Downstream consumer of the 64x9216 display VRAM copy.
- Once per frame, runs two passes over the accumulated per-pixel beam power:
  - pass 1 finds the frame maximum;
  - pass 2 normalises each pixel to 8 bits by a shift derived from that maximum.
- Emits the frame as an AXI4-Stream RGB888 video stream to the VDMA write channel.
- Sits between the VRAM read port (addr_vdma/data_vdma) and the VDMA S2MM input.

Parameters:
- NPIX, 9216: pixels per frame; the image is 96x96.
- LINE_W, 96: pixels per line; tlast asserts on each line end.
- RD_LAT, 1: VRAM read latency in clocks. Legal values are 1 and 2.
- FIFO_DEPTH, 4: depth of the output skid FIFO. Must be ≥ RD_LAT+2.

Ports:
- clk_vdma, input, 1: display/VDMA clock. Only clock in the block.
- rst_n, input, 1: asynchronous reset, active-low.
- frame_start, input, 1: single-cycle pulse requesting one frame conversion.
- addr_vdma, output, 14: VRAM read address.
- data_vdma, input, 64: VRAM read data, valid RD_LAT clocks after the address.
- m_axis_tdata, output, 24: pixel data as {R,G,B}.
- m_axis_tvalid, output, 1: AXI-Stream valid.
- m_axis_tready, input, 1: AXI-Stream ready.
- m_axis_tuser, output, 1: start of frame; high on pixel 0 only.
- m_axis_tlast, output, 1: end of line; high on pixels 95, 191, …, 9215.
- busy, output, 1: high from accepted frame_start until the last pixel handshake.
- frame_done, output, 1: one-cycle pulse after the last pixel handshake.
- frame_max, output, 64: maximum found in the last SCAN pass. Held until the next SCAN completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; addr_vdma=0; tvalid/tuser/tlast=0; tdata=0; busy=0; frame_done=0; frame_max=0; FIFO empty; in-flight counter 0.
  - Reset mid-frame abandons the frame with no partial handshake completed afterwards.
- Data interpretation: each 64-bit word is treated as signed. Negative words (bit63=1) count as 0 for both max search and pixel value.
- States: IDLE → SCAN → CALC → STREAM → IDLE.
- IDLE:
  - frame_start moves to SCAN; addr_vdma=0; busy asserts the next cycle.
  - frame_start is ignored in any state other than IDLE.
- SCAN:
  - Issues addresses 0..9215, one per clock, with no stall.
  - Samples returned data RD_LAT clocks later and keeps a running unsigned max.
  - Leaves for CALC once the last sample (address 9215) is absorbed.
  - Duration is NPIX+RD_LAT clocks.
- CALC, one clock:
  - frame_max is updated.
  - p = index of the most significant 1 in max.
  - sh = (p>7) ? p-7 : 0.
  - If max==0, sh=0 and all pixels are 0.
  - addr_vdma resets to 0.
- STREAM:
  - Issues a read only when fifo_count + inflight < FIFO_DEPTH; the address increments per issued read.
  - Each returned word w gives v = min(w>>sh, 255), or 0 if w is negative. Because sh comes from max, v never exceeds 255 when max>0.
  - Greyscale mapping: tdata = {v,v,v}.
  - A FIFO entry carries {tdata, tuser, tlast}. tuser is set for pixel index 0; tlast is set when (index mod LINE_W) == LINE_W-1.
  - FIFO head drives the m_axis outputs. tvalid = FIFO non-empty. Pop occurs on tvalid&tready.
  - Output data is held stable while tvalid=1 and tready=0 (AXI rule).
  - Simultaneous push and pop on a full FIFO is legal.
  - After the pixel-9215 handshake: frame_done pulses for one clock, busy drops, state returns to IDLE.
- Throughput: with tready held high, one pixel per clock after an initial latency of RD_LAT+1 clocks (plus the colormap stage when enabled).
- Backpressure never drops or duplicates pixels.
- tready toggling on any cycle pattern must still yield exactly 9216 handshakes per frame.

Optional Feature:
- Macro: HEATMAP_COLORMAP_EN.
- Defined:
  - Inserts one register stage applying a "hot" map before the FIFO.
  - R = sat(3v), G = sat(3v-255), B = sat(3v-510), each saturated to the range 0..255.
  - Adds one clock of latency; that stage counts toward inflight.
- Undefined: greyscale {v,v,v} with no extra stage.

Test Plan:
- Ramp frame:
  - VRAM[i]=i, tready=1.
  - Expect frame_max=9215, p=13, sh=6.
  - Pixel i = min(i>>6, 255); pixel 9215 = 143.
  - 9216 beats; tuser on beat 0 only; tlast on beats 95 and 9215.
- All-zero frame: every word 0 → frame_max=0; all tdata=0x000000; frame_done pulses once.
- Negative clamp:
  - VRAM[0]=-5 (0xFFFF…FFFB), VRAM[1]=1000, rest 0.
  - Expect frame_max=1000, sh=2.
  - Pixel 0 = 0x000000; pixel 1 = {250,250,250}.
- Backpressure: ramp frame with tready pseudo-random at 30% duty → identical data sequence to the first test; tdata stable during every tvalid&!tready cycle.
- Ignored start and reset:
  - frame_start pulsed during SCAN and during STREAM → no restart.
  - rst_n pulled low at pixel 4000 → tvalid=0 immediately; state IDLE.
  - Next frame_start produces a full 9216-beat frame.
- HEATMAP_COLORMAP_EN defined: v=100 → tdata=0xFF2D00; v=255 → 0xFFFFFF; v=50 → 0x960000.
